magnetron_timer: RTL and testbench
==================================

Name: magnetron_timer

Overview:
Cook-time and magnetron power controller fed by the microwave's Set/Reset control logic. Holds a 4-digit BCD mm:ss cook time entered from the keypad and runs the magnetron while counting it down. Returns tdone to the control logic when the time expires, closing the Set/Reset/tdone loop.

Parameters:
TICK_DIV, 100, clock cycles per cook second (prescaler modulus, >=2)

Ports:
clk  in  1  system clock
rstN  in  1  asynchronous active-low reset
Set  in  1  start/resume request from control logic (level, sampled each cycle)
Reset  in  1  stop request from control logic (level; priority over Set)
keyValid  in  1  one-cycle strobe: keyDigit holds a pressed digit
keyDigit  in  4  BCD digit 0-9; values 10-15 ignored
limpaN  in  1  clear request, active-low, synchronous level
magnetronOn  out  1  magnetron enable, high only in COOK
tdone  out  1  time expired, high while in DONE
timeBcd  out  16  {min10,min1,sec10,sec1} for display
secTick  out  1  one-cycle pulse on each decrement

Behaviour:
- Reset (rstN=0): state IDLE, timeBcd=0, prescaler=0, magnetronOn=0, tdone=0, secTick=0. All outputs are registered.
- States: IDLE (time==0), READY (time!=0, stopped), COOK, PAUSE, DONE.
- Priority each cycle: limpaN=0 > Reset > Set > keyValid.
- limpaN=0 in any state: timeBcd<=0, go to IDLE.
- Digit entry: allowed in IDLE, READY and DONE only. keyValid with keyDigit<=9 shifts left: timeBcd<={timeBcd[11:0],keyDigit}. Next state is READY if the result is nonzero, else IDLE. keyValid in COOK/PAUSE is ignored. Digits >9 are ignored in every state.
- Set in READY or PAUSE -> COOK. Set in IDLE, DONE or COOK -> no effect (see ADD30_EN).
- Reset in COOK -> PAUSE, time kept. Reset elsewhere -> no state change.
- COOK countdown:
  - Prescaler counts 0..TICK_DIV-1. On wrap, decrement timeBcd and pulse secTick for one cycle.
  - The first decrement occurs TICK_DIV cycles after entering COOK.
  - Prescaler is forced to 0 whenever the state is not COOK; a resumed cook restarts a full second.
- Decrement rule (BCD):
  - If sec1!=0: sec1-1.
  - Else if sec10!=0: sec1=9, sec10-1.
  - Else if minutes!=0: seconds=59, minutes-1 in BCD (min1 borrows from min10).
  - Entered sec10 values of 6-9 are legal and count down as-is; for example, 00:90 lasts 90 s.
- Expiry: a decrement producing 00:00 moves to DONE in the same edge. magnetronOn drops and tdone rises on that edge.
- DONE: tdone=1 until limpaN=0 (-> IDLE) or a valid digit (-> READY/IDLE via shift from 0000).
- Simultaneous events: Reset and tick on the same cycle -> the decrement is applied and the state becomes PAUSE. If that decrement reaches 00:00, the state is DONE. limpaN overrides a coincident tick.
- rstN asserted mid-cook: magnetron off immediately (asynchronous); all state lost.

Optional Feature:
ADD30_EN. When defined, Set gives quick-start behaviour:
- In IDLE or DONE: load 00:30 and enter COOK.
- In COOK: add 30 s. sec10+=3; if the result is >5, subtract 6 and carry 1 into minutes (BCD).
- The result saturates at 99:59. The prescaler is not disturbed.

When undefined, Set in IDLE, DONE and COOK is ignored exactly as above.

Test Plan:
- TICK_DIV=4; keys 1,2 -> timeBcd=0x0012, READY; Set -> magnetronOn=1 next edge; first secTick 4 cycles later, time 0x0011.
- Load 0x0100, Set -> after 4 cycles time=0x0059; after 59 more ticks, 0x0000 -> tdone=1, magnetronOn=0 same edge; tdone stays high until keyValid digit 5 -> time 0x0005, READY, tdone=0.
- COOK at 0x0030, Reset after 2 cycles -> PAUSE, time 0x0030, magnetronOn=0; Set -> COOK, decrement 4 cycles later (prescaler restarted) to 0x0029.
- In COOK assert keyValid digit 7 and Set together -> time unchanged; limpaN=0 with Reset -> IDLE, timeBcd=0; Set in IDLE -> no change (ADD30_EN off).
- rstN pulsed low mid-COOK between edges -> magnetronOn=0, timeBcd=0 immediately; keyDigit=0xA strobe -> ignored.
- ADD30_EN: Set in IDLE -> 0x0030 COOK; Set at 0x0045 -> 0x0115; Set at 0x9950 -> 0x9959.

Source files
------------

// File: rtl/magnetron_timer.sv
// magnetron_timer -- cook-time countdown and magnetron enable.
//
// The 4-digit BCD mm:ss cook time is entered from the keypad. The magnetron
// runs while the time counts down once per cook second. When the time
// expires, tdone is returned to the Set/Reset control logic.
//
// Optional feature (compile-time macro ADD30_EN): quick-start. Set in IDLE or
// DONE loads 00:30 and starts cooking. Set in COOK adds 30 s, saturating at
// 99:59. Without the macro, Set in IDLE/DONE/COOK is ignored.
//
// Parameters:
//   TICK_DIV     clock cycles per cook second (>= 2)
// Ports:
//   clk          system clock
//   rstN         asynchronous active-low reset
//   Set          start/resume request (level)
//   Reset        stop request (level, priority over Set)
//   keyValid     one-cycle strobe, keyDigit holds a pressed digit
//   keyDigit     BCD digit 0-9 (10-15 ignored)
//   limpaN       synchronous clear, active-low
//   magnetronOn  magnetron enable, high only while cooking
//   tdone        time expired, high while in DONE
//   timeBcd      {min10, min1, sec10, sec1}
//   secTick      one-cycle pulse on each decrement
module magnetron_timer #(
  parameter int TICK_DIV = 100
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        Set,
  input  logic        Reset,
  input  logic        keyValid,
  input  logic [3:0]  keyDigit,
  input  logic        limpaN,
  output logic        magnetronOn,
  output logic        tdone,
  output logic [15:0] timeBcd,
  output logic        secTick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state, nxt;
  logic [PW-1:0] presc, presc_n;
  logic [15:0]   time_n;
  logic [15:0]   tdec;
  logic          tick;

  // One-second BCD decrement. sec10 values 6-9 are counted down as entered.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else if (t[7:4] != 4'd0) begin
      r[3:0] = 4'd9;
      r[7:4] = t[7:4] - 4'd1;
    end else if (t[15:8] != 8'd0) begin
      r[7:0] = 8'h59;
      if (t[11:8] != 4'd0) begin
        r[11:8] = t[11:8] - 4'd1;
      end else begin
        r[11:8]  = 4'd9;
        r[15:12] = t[15:12] - 4'd1;
      end
    end
    return r;
  endfunction

`ifdef ADD30_EN
  // Add 30 s to a BCD mm:ss value, saturating at 99:59.
  function automatic logic [15:0] bcd_add30(input logic [15:0] t);
    logic [4:0]  s10;
    logic        carry;
    logic [15:0] r;
    s10   = {1'b0, t[7:4]} + 5'd3;
    carry = 1'b0;
    if (s10 > 5'd5) begin
      s10   = s10 - 5'd6;
      carry = 1'b1;
    end
    r = {t[15:8], s10[3:0], t[3:0]};
    if (carry) begin
      if (t[11:8] != 4'd9) begin
        r[11:8] = t[11:8] + 4'd1;
      end else if (t[15:12] != 4'd9) begin
        r[11:8]  = 4'd0;
        r[15:12] = t[15:12] + 4'd1;
      end else begin
        r = 16'h9959;
      end
    end
    return r;
  endfunction
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= IDLE;
      timeBcd     <= 16'h0000;
      presc       <= '0;
      magnetronOn <= 1'b0;
      tdone       <= 1'b0;
      secTick     <= 1'b0;
    end else begin
      state       <= nxt;
      timeBcd     <= time_n;
      presc       <= presc_n;
      magnetronOn <= (nxt == COOK);
      tdone       <= (nxt == DONE);
      secTick     <= tick && limpaN;
    end
  end

  always_comb begin
    nxt    = state;
    time_n = timeBcd;
    tdec   = bcd_dec(timeBcd);
    tick   = (state == COOK) && (presc == PMAX);

    if (!limpaN) begin
      time_n = 16'h0000;
      nxt    = IDLE;
    end else begin
      if (tick) begin
        time_n = tdec;
        nxt    = (tdec == 16'h0000) ? DONE : COOK;
      end
      if (Reset) begin
        // A coincident tick has already been applied; expiry still wins.
        if (state == COOK && nxt == COOK) nxt = PAUSE;
      end else if (Set) begin
        case (state)
          READY, PAUSE: nxt = COOK;
`ifdef ADD30_EN
          IDLE, DONE: begin
            time_n = 16'h0030;
            nxt    = COOK;
          end
          COOK: begin
            time_n = bcd_add30(time_n);
            nxt    = COOK;
          end
`endif
          default: ;
        endcase
      end else if (keyValid && keyDigit <= 4'd9 &&
                   (state == IDLE || state == READY || state == DONE)) begin
        time_n = {timeBcd[11:0], keyDigit};
        nxt    = (time_n != 16'h0000) ? READY : IDLE;
      end
    end

    // A resumed or restarted cook always begins a full second.
    presc_n = (state == COOK && nxt == COOK && !tick) ? presc + PW'(1) : '0;
  end

endmodule

// File: tb/tb_magnetron_timer.sv
module tb_magnetron_timer;
  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        Set = 1'b0;
  logic        Reset = 1'b0;
  logic        keyValid = 1'b0;
  logic [3:0]  keyDigit = 4'd0;
  logic        limpaN = 1'b1;
  logic        magnetronOn;
  logic        tdone;
  logic [15:0] timeBcd;
  logic        secTick;

  int checks = 0;
  int failures = 0;

  magnetron_timer #(.TICK_DIV(4)) dut (
    .clk(clk), .rstN(rstN), .Set(Set), .Reset(Reset), .keyValid(keyValid),
    .keyDigit(keyDigit), .limpaN(limpaN), .magnetronOn(magnetronOn),
    .tdone(tdone), .timeBcd(timeBcd), .secTick(secTick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    keyValid = 1'b1;
    keyDigit = d;
    step();
    keyValid = 1'b0;
  endtask

  task automatic clear();
    limpaN = 1'b0;
    step();
    limpaN = 1'b1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    #12;
    checks++; if (timeBcd !== 16'h0000) begin failures++; $display("FAIL reset_time got=%h exp=0000", timeBcd); end
    checks++; if (magnetronOn !== 1'b0) begin failures++; $display("FAIL reset_mag got=%b exp=0", magnetronOn); end
    checks++; if (tdone !== 1'b0) begin failures++; $display("FAIL reset_tdone got=%b exp=0", tdone); end
    checks++; if (secTick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", secTick); end
    @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  task automatic test_entry_cook();
    press(4'd1);
    press(4'd2);
    checks++; if (timeBcd !== 16'h0012) begin failures++; $display("FAIL entry_time got=%h exp=0012", timeBcd); end
    checks++; if (magnetronOn !== 1'b0) begin failures++; $display("FAIL ready_mag got=%b exp=0", magnetronOn); end
    Set = 1'b1;
    step();
    Set = 1'b0;
    checks++; if (magnetronOn !== 1'b1) begin failures++; $display("FAIL cook_mag got=%b exp=1", magnetronOn); end
    repeat (3) step();
    checks++; if (timeBcd !== 16'h0012 || secTick !== 1'b0) begin failures++; $display("FAIL early_tick time=%h tick=%b exp=0012/0", timeBcd, secTick); end
    step();
    checks++; if (timeBcd !== 16'h0011 || secTick !== 1'b1) begin failures++; $display("FAIL first_tick time=%h tick=%b exp=0011/1", timeBcd, secTick); end
    step();
    checks++; if (secTick !== 1'b0) begin failures++; $display("FAIL tick_pulse got=%b exp=0", secTick); end
    clear();
    checks++; if (timeBcd !== 16'h0000 || magnetronOn !== 1'b0) begin failures++; $display("FAIL limpa_clear time=%h mag=%b exp=0000/0", timeBcd, magnetronOn); end
  endtask

  task automatic test_expiry();
    press(4'd1);
    press(4'd0);
    press(4'd0);
    Set = 1'b1;
    step();
    Set = 1'b0;
    repeat (4) step();
    checks++; if (timeBcd !== 16'h0059) begin failures++; $display("FAIL min_borrow got=%h exp=0059", timeBcd); end
    repeat (232) step();
    checks++; if (timeBcd !== 16'h0001 || tdone !== 1'b0 || magnetronOn !== 1'b1) begin failures++; $display("FAIL pre_expiry time=%h tdone=%b mag=%b exp=0001/0/1", timeBcd, tdone, magnetronOn); end
    repeat (4) step();
    checks++; if (timeBcd !== 16'h0000 || tdone !== 1'b1 || magnetronOn !== 1'b0) begin failures++; $display("FAIL expiry time=%h tdone=%b mag=%b exp=0000/1/0", timeBcd, tdone, magnetronOn); end
    repeat (5) step();
    checks++; if (tdone !== 1'b1 || timeBcd !== 16'h0000) begin failures++; $display("FAIL done_hold tdone=%b time=%h exp=1/0000", tdone, timeBcd); end
    press(4'd5);
    checks++; if (timeBcd !== 16'h0005 || tdone !== 1'b0) begin failures++; $display("FAIL done_key time=%h tdone=%b exp=0005/0", timeBcd, tdone); end
    Set = 1'b1;
    step();
    Set = 1'b0;
    checks++; if (magnetronOn !== 1'b1) begin failures++; $display("FAIL ready_after_done mag=%b exp=1", magnetronOn); end
    clear();
  endtask

  task automatic test_pause_resume();
    press(4'd3);
    press(4'd0);
    Set = 1'b1;
    step();
    Set = 1'b0;
    repeat (2) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checks++; if (magnetronOn !== 1'b0 || timeBcd !== 16'h0030) begin failures++; $display("FAIL pause mag=%b time=%h exp=0/0030", magnetronOn, timeBcd); end
    repeat (3) step();
    checks++; if (magnetronOn !== 1'b0 || timeBcd !== 16'h0030) begin failures++; $display("FAIL pause_hold mag=%b time=%h exp=0/0030", magnetronOn, timeBcd); end
    Set = 1'b1;
    step();
    Set = 1'b0;
    checks++; if (magnetronOn !== 1'b1) begin failures++; $display("FAIL resume mag=%b exp=1", magnetronOn); end
    repeat (3) step();
    checks++; if (timeBcd !== 16'h0030) begin failures++; $display("FAIL presc_restart got=%h exp=0030", timeBcd); end
    step();
    checks++; if (timeBcd !== 16'h0029 || secTick !== 1'b1) begin failures++; $display("FAIL sec10_borrow time=%h tick=%b exp=0029/1", timeBcd, secTick); end
    repeat (3) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checks++; if (timeBcd !== 16'h0028 || magnetronOn !== 1'b0 || secTick !== 1'b1) begin failures++; $display("FAIL reset_with_tick time=%h mag=%b tick=%b exp=0028/0/1", timeBcd, magnetronOn, secTick); end
  endtask

  task automatic test_ignore();
    Set = 1'b1;
    step();
    Set = 1'b0;
    Set = 1'b1;
    keyValid = 1'b1;
    keyDigit = 4'd7;
    step();
    Set = 1'b0;
    keyValid = 1'b0;
`ifndef ADD30_EN
    checks++; if (timeBcd !== 16'h0028) begin failures++; $display("FAIL cook_key_ignored got=%h exp=0028", timeBcd); end
`endif
    checks++; if (magnetronOn !== 1'b1) begin failures++; $display("FAIL cook_key_mag got=%b exp=1", magnetronOn); end
    limpaN = 1'b0;
    Reset = 1'b1;
    step();
    limpaN = 1'b1;
    Reset = 1'b0;
    checks++; if (timeBcd !== 16'h0000 || magnetronOn !== 1'b0) begin failures++; $display("FAIL limpa_over_reset time=%h mag=%b exp=0000/0", timeBcd, magnetronOn); end
`ifndef ADD30_EN
    Set = 1'b1;
    step();
    Set = 1'b0;
    checks++; if (timeBcd !== 16'h0000 || magnetronOn !== 1'b0) begin failures++; $display("FAIL idle_set time=%h mag=%b exp=0000/0", timeBcd, magnetronOn); end
`endif
  endtask

  task automatic test_shift();
    press(4'd1);
    press(4'd2);
    press(4'd3);
    press(4'd4);
    press(4'd5);
    checks++; if (timeBcd !== 16'h2345) begin failures++; $display("FAIL shift_out got=%h exp=2345", timeBcd); end
    press(4'd12);
    checks++; if (timeBcd !== 16'h2345) begin failures++; $display("FAIL bad_digit_ready got=%h exp=2345", timeBcd); end
    clear();
  endtask

  task automatic test_async_reset();
    press(4'd4);
    Set = 1'b1;
    step();
    Set = 1'b0;
    step();
    #3;
    rstN = 1'b0;
    #1;
    checks++; if (magnetronOn !== 1'b0 || timeBcd !== 16'h0000) begin failures++; $display("FAIL async_reset mag=%b time=%h exp=0/0000", magnetronOn, timeBcd); end
    #1;
    rstN = 1'b1;
    press(4'hA);
    checks++; if (timeBcd !== 16'h0000 || magnetronOn !== 1'b0) begin failures++; $display("FAIL bad_digit_idle time=%h mag=%b exp=0000/0", timeBcd, magnetronOn); end
  endtask

`ifdef ADD30_EN
  task automatic test_add30();
    Set = 1'b1;
    step();
    Set = 1'b0;
    checks++; if (timeBcd !== 16'h0030 || magnetronOn !== 1'b1) begin failures++; $display("FAIL quick_start time=%h mag=%b exp=0030/1", timeBcd, magnetronOn); end
    clear();
    press(4'd4);
    press(4'd5);
    Set = 1'b1;
    step();
    step();
    Set = 1'b0;
    checks++; if (timeBcd !== 16'h0115) begin failures++; $display("FAIL add30_carry got=%h exp=0115", timeBcd); end
    clear();
    press(4'd9);
    press(4'd9);
    press(4'd5);
    press(4'd0);
    Set = 1'b1;
    step();
    step();
    Set = 1'b0;
    checks++; if (timeBcd !== 16'h9959) begin failures++; $display("FAIL add30_sat got=%h exp=9959", timeBcd); end
    clear();
  endtask
`endif

  initial begin
    test_reset();
    test_entry_cook();
    test_expiry();
    test_pause_resume();
    test_ignore();
    test_shift();
    test_async_reset();
`ifdef ADD30_EN
    test_add30();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
